data_mem_controller: RTL and testbench
======================================

Name: data_mem_controller

Overview:
- Responder side of the per-thread LSU data-memory handshake.
- Accepts read and write requests from NUM_CONSUMERS LSUs over valid/ready and multiplexes them onto NUM_CHANNELS external data-memory channels.
- Returns read data and completion (ready) to the requesting LSU.
- Sits between all LSUs of a core and the data-memory port.

Parameters:
NUM_CONSUMERS, 4, number of LSU request ports
NUM_CHANNELS, 2, number of concurrent external memory channels (1..NUM_CONSUMERS)
ADDR_BITS, 8, data-memory address width
DATA_BITS, 16, data word width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
consumer_read_valid  in  NUM_CONSUMERS  per-LSU read request
consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  packed read addresses, consumer i at [i*ADDR_BITS +: ADDR_BITS]
consumer_read_ready  out  NUM_CONSUMERS  read complete, data valid
consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  packed read data
consumer_write_valid  in  NUM_CONSUMERS  per-LSU write request
consumer_write_address  in  NUM_CONSUMERS*ADDR_BITS  packed write addresses
consumer_write_data  in  NUM_CONSUMERS*DATA_BITS  packed write data
consumer_write_ready  out  NUM_CONSUMERS  write complete
mem_read_valid  out  NUM_CHANNELS  channel read request
mem_read_address  out  NUM_CHANNELS*ADDR_BITS  channel read address
mem_read_ready  in  NUM_CHANNELS  memory read response valid
mem_read_data  in  NUM_CHANNELS*DATA_BITS  memory read data
mem_write_valid  out  NUM_CHANNELS  channel write request
mem_write_address  out  NUM_CHANNELS*ADDR_BITS  channel write address
mem_write_data  out  NUM_CHANNELS*DATA_BITS  channel write data
mem_write_ready  in  NUM_CHANNELS  memory write accepted

Behaviour:
- All outputs registered.
- Reset (async): all outputs 0, every channel IDLE, claim mask 0, scan pointers 0.
- Per-channel FSM states: IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING.
- IDLE:
  - Scan consumers for unclaimed ones with read_valid or write_valid; take the first found. If a consumer has both, read wins.
  - Set claim bit, store consumer index, register the address (and data for writes).
  - Assert mem_read_valid or mem_write_valid; go to READ_WAITING or WRITE_WAITING.
- Same-cycle claims: channels resolve in ascending index order. A consumer claimed by a lower channel this cycle is invisible to higher channels, so no consumer is ever served by two channels.
- READ_WAITING: on mem_read_ready=1, drop mem_read_valid, latch mem_read_data into consumer_read_data, set consumer_read_ready=1, go to READ_RELAYING. Otherwise hold; no timeout.
- WRITE_WAITING: on mem_write_ready=1, drop mem_write_valid, set consumer_write_ready=1, go to WRITE_RELAYING.
- READ_RELAYING / WRITE_RELAYING:
  - Hold ready and data until the consumer's valid is seen low.
  - Then clear ready, release the claim bit, return to IDLE.
  - The released consumer is not re-claimable in that same cycle.
- Latency: valid seen at edge T gives mem valid after T. Memory ready at edge T+k gives consumer ready after T+k. Minimum k = 1.
- More requests than channels: extras wait in IDLE scan; no request is dropped.
- Consumer valid dropping while in WAITING is illegal; the controller still completes the memory transaction.
- Reset mid-transaction abandons it: mem valid goes low immediately.

Optional Feature:
MEM_CTRL_RR_EN
- Defined: each channel keeps a scan pointer set to (served index + 1) mod NUM_CONSUMERS on claim. The scan starts there, giving round-robin fairness.
- Undefined: every scan starts at consumer 0 (fixed priority); no pointer registers.

Test Plan:
- Single read: consumer 2 reads addr 0x1A; memory ready after 3 cycles with 0xBEEF -> consumer_read_data[2]=0xBEEF, ready held until read_valid drops, then 0 and channel IDLE.
- Single write: consumer 0 writes 0x55AA to 0x03 -> mem_write_address=0x03, mem_write_data=0x55AA; consumer_write_ready[0] pulses after mem_write_ready; no second mem write issued.
- Oversubscription: all 4 consumers read in the same cycle, 2 channels -> consumers 0,1 on channels 0,1 first; 2,3 served after release; each gets its own address-tagged data.
- Duplicate-service check: consumer 1 holds valid across ready -> exactly one mem_read_valid pulse for it; its claim bit is never set on two channels.
- Fairness (MEM_CTRL_RR_EN defined): 1 channel, consumers 0 and 3 continuously requesting -> service order alternates 0,3,0,3. Undefined: 0 served each time it requests after release.
- Async reset asserted in READ_WAITING -> all outputs 0 without a clock edge; the next request after reset is served normally.

Source files
------------

// File: rtl/data_mem_controller.sv
// Responder for the per-thread LSU data-memory handshake: arbitrates NUM_CONSUMERS LSUs onto NUM_CHANNELS memory channels.
// Optional MEM_CTRL_RR_EN: per-channel round-robin scan pointer; otherwise every scan starts at consumer 0.
module data_mem_controller #(
  parameter int unsigned NUM_CONSUMERS = 4,
  parameter int unsigned NUM_CHANNELS  = 2,
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned DATA_BITS     = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

  localparam int unsigned IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAITING,
    WRITE_WAITING,
    READ_RELAYING,
    WRITE_RELAYING
  } state_t;

  state_t                   state [NUM_CHANNELS];
  logic [IDX_W-1:0]         owner [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] claimed;

  logic [NUM_CHANNELS-1:0]  pick_valid;
  logic [NUM_CHANNELS-1:0]  pick_read;
  logic [IDX_W-1:0]         pick_idx [NUM_CHANNELS];

`ifdef MEM_CTRL_RR_EN
  logic [IDX_W-1:0]         scan_ptr [NUM_CHANNELS];
`endif

  // Same-cycle claims resolve in ascending channel order; a consumer taken by a lower channel is hidden from higher ones.
  always_comb begin
    logic [NUM_CONSUMERS-1:0] taken;
    logic [IDX_W-1:0]         cand;
    int                       start;
    int                       idx;
    taken      = claimed;
    pick_valid = '0;
    pick_read  = '0;
    cand       = '0;
    start      = 0;
    idx        = 0;
    for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
      pick_idx[c] = '0;
`ifdef MEM_CTRL_RR_EN
      start = int'(scan_ptr[c]);
`else
      start = 0;
`endif
      for (int k = 0; k < int'(NUM_CONSUMERS); k++) begin
        idx = start + k;
        if (idx >= int'(NUM_CONSUMERS)) idx = idx - int'(NUM_CONSUMERS);
        cand = IDX_W'(idx);
        if (state[c] == IDLE && !pick_valid[c] && !taken[cand] &&
            (consumer_read_valid[cand] || consumer_write_valid[cand])) begin
          pick_valid[c] = 1'b1;
          pick_idx[c]   = cand;
          pick_read[c]  = consumer_read_valid[cand];
          taken[cand]   = 1'b1;
        end
      end
    end
  end

  // Per-channel request/relay FSMs; the claim register stays set through relaying so a release is never re-claimed the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
        state[c] <= IDLE;
        owner[c] <= '0;
`ifdef MEM_CTRL_RR_EN
        scan_ptr[c] <= '0;
`endif
      end
      claimed              <= '0;
      consumer_read_ready  <= '0;
      consumer_read_data   <= '0;
      consumer_write_ready <= '0;
      mem_read_valid       <= '0;
      mem_read_address     <= '0;
      mem_write_valid      <= '0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
    end else begin
      for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
        case (state[c])
          IDLE: begin
            if (pick_valid[c]) begin
              claimed[pick_idx[c]] <= 1'b1;
              owner[c]             <= pick_idx[c];
`ifdef MEM_CTRL_RR_EN
              scan_ptr[c] <= (int'(pick_idx[c]) == int'(NUM_CONSUMERS) - 1) ? '0 : pick_idx[c] + 1'b1;
`endif
              if (pick_read[c]) begin
                mem_read_valid[c] <= 1'b1;
                mem_read_address[c*ADDR_BITS +: ADDR_BITS] <=
                  consumer_read_address[int'(pick_idx[c])*ADDR_BITS +: ADDR_BITS];
                state[c] <= READ_WAITING;
              end else begin
                mem_write_valid[c] <= 1'b1;
                mem_write_address[c*ADDR_BITS +: ADDR_BITS] <=
                  consumer_write_address[int'(pick_idx[c])*ADDR_BITS +: ADDR_BITS];
                mem_write_data[c*DATA_BITS +: DATA_BITS] <=
                  consumer_write_data[int'(pick_idx[c])*DATA_BITS +: DATA_BITS];
                state[c] <= WRITE_WAITING;
              end
            end
          end
          READ_WAITING: begin
            if (mem_read_ready[c]) begin
              mem_read_valid[c] <= 1'b0;
              consumer_read_data[int'(owner[c])*DATA_BITS +: DATA_BITS] <=
                mem_read_data[c*DATA_BITS +: DATA_BITS];
              consumer_read_ready[owner[c]] <= 1'b1;
              state[c] <= READ_RELAYING;
            end
          end
          WRITE_WAITING: begin
            if (mem_write_ready[c]) begin
              mem_write_valid[c]             <= 1'b0;
              consumer_write_ready[owner[c]] <= 1'b1;
              state[c]                       <= WRITE_RELAYING;
            end
          end
          READ_RELAYING: begin
            if (!consumer_read_valid[owner[c]]) begin
              consumer_read_ready[owner[c]] <= 1'b0;
              claimed[owner[c]]             <= 1'b0;
              state[c]                      <= IDLE;
            end
          end
          WRITE_RELAYING: begin
            if (!consumer_write_valid[owner[c]]) begin
              consumer_write_ready[owner[c]] <= 1'b0;
              claimed[owner[c]]              <= 1'b0;
              state[c]                       <= IDLE;
            end
          end
          default: state[c] <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_mem_controller.sv
// Bench for data_mem_controller: directed handshake scenarios, then random LSU traffic against a memory-image reference model.
module tb_data_mem_controller;

  localparam int unsigned NC     = 4;
  localparam int unsigned NCH    = 2;
  localparam int unsigned AW     = 8;
  localparam int unsigned DW     = 16;
  localparam int unsigned N_RAND = 40;

  logic            clk   = 1'b0;
  logic            reset = 1'b1;
  logic [NC-1:0]   consumer_read_valid   = '0;
  logic [NC*AW-1:0] consumer_read_address = '0;
  logic [NC-1:0]   consumer_read_ready;
  logic [NC*DW-1:0] consumer_read_data;
  logic [NC-1:0]   consumer_write_valid   = '0;
  logic [NC*AW-1:0] consumer_write_address = '0;
  logic [NC*DW-1:0] consumer_write_data    = '0;
  logic [NC-1:0]   consumer_write_ready;
  logic [NCH-1:0]  mem_read_valid;
  logic [NCH*AW-1:0] mem_read_address;
  logic [NCH-1:0]  mem_read_ready = '0;
  logic [NCH*DW-1:0] mem_read_data = '0;
  logic [NCH-1:0]  mem_write_valid;
  logic [NCH*AW-1:0] mem_write_address;
  logic [NCH*DW-1:0] mem_write_data;
  logic [NCH-1:0]  mem_write_ready = '0;

  data_mem_controller #(
    .NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH), .ADDR_BITS(AW), .DATA_BITS(DW)
  ) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(consumer_read_valid), .consumer_read_address(consumer_read_address),
    .consumer_read_ready(consumer_read_ready), .consumer_read_data(consumer_read_data),
    .consumer_write_valid(consumer_write_valid), .consumer_write_address(consumer_write_address),
    .consumer_write_data(consumer_write_data), .consumer_write_ready(consumer_write_ready),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int rd_req_cnt = 0;
  int wr_req_cnt = 0;
  int done_cnt   = 0;
  bit rand_done  = 1'b0;
  logic [NCH-1:0] prev_rv = '0;
  logic [NCH-1:0] prev_wv = '0;

  // Memory image behind the channels, and the image each LSU expects to see.
  logic [DW-1:0] mem_arr   [256];
  logic [DW-1:0] model_arr [256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

`ifdef MEM_CTRL_RR_EN
  function automatic int rr_next(input int last);
    for (int k = 1; k <= 4; k++)
      if (((last + k) % 4) == 0 || ((last + k) % 4) == 3) return (last + k) % 4;
    return 0;
  endfunction
`endif

  // Counts new memory requests as rising edges of each channel valid.
  always @(negedge clk) begin
    for (int c = 0; c < int'(NCH); c++) begin
      if (mem_read_valid[c] && !prev_rv[c]) rd_req_cnt++;
      if (mem_write_valid[c] && !prev_wv[c]) wr_req_cnt++;
    end
    prev_rv = mem_read_valid;
    prev_wv = mem_write_valid;
  end

  task automatic lsu_run(input int id);
    bit            is_rd;
    logic [5:0]    hi;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            n;
    for (int t = 0; t < int'(N_RAND); t++) begin
      is_rd = 1'($urandom_range(0, 1));
      hi    = 6'($urandom);
      a     = {hi, 2'(id)};
      d     = 16'($urandom);
      repeat (1 + $urandom_range(0, 3)) @(negedge clk);
      if (is_rd) begin
        consumer_read_address[id*AW +: AW] = a;
        consumer_read_valid[id] = 1'b1;
      end else begin
        consumer_write_address[id*AW +: AW] = a;
        consumer_write_data[id*DW +: DW] = d;
        consumer_write_valid[id] = 1'b1;
      end
      n = 0;
      do begin
        step();
        n++;
      end while (!(is_rd ? consumer_read_ready[id] : consumer_write_ready[id]) && n < 300);
      check("lsu_done", 32'(is_rd ? consumer_read_ready[id] : consumer_write_ready[id]), 32'd1);
      if (is_rd) check("lsu_rdata", 32'(consumer_read_data[id*DW +: DW]), 32'(model_arr[a]));
      else model_arr[a] = d;
      done_cnt++;
      consumer_read_valid[id]  = 1'b0;
      consumer_write_valid[id] = 1'b0;
      step();
      check("lsu_ready_clr", 32'({consumer_read_ready[id], consumer_write_ready[id]}), 32'd0);
    end
  endtask

  task automatic mem_run(input int ch);
    logic [AW-1:0] a;
    int            guard;
    guard = 0;
    while (!rand_done && guard < 50000) begin
      @(negedge clk);
      guard++;
      if (mem_read_valid[ch]) begin
        a = mem_read_address[ch*AW +: AW];
        repeat ($urandom_range(0, 3)) @(negedge clk);
        check("mem_rd_hold", 32'(mem_read_valid[ch]), 32'd1);
        mem_read_data[ch*DW +: DW] = mem_arr[a];
        mem_read_ready[ch] = 1'b1;
        step();
        mem_read_ready[ch] = 1'b0;
        check("rd_ready_lat", 32'(consumer_read_ready[a[1:0]]), 32'd1);
        check("rd_relay_data", 32'(consumer_read_data[int'(a[1:0])*DW +: DW]), 32'(mem_arr[a]));
        check("rd_valid_drop", 32'(mem_read_valid[ch]), 32'd0);
      end else if (mem_write_valid[ch]) begin
        a = mem_write_address[ch*AW +: AW];
        repeat ($urandom_range(0, 3)) @(negedge clk);
        check("mem_wr_hold", 32'(mem_write_valid[ch]), 32'd1);
        mem_arr[a] = mem_write_data[ch*DW +: DW];
        mem_write_ready[ch] = 1'b1;
        step();
        mem_write_ready[ch] = 1'b0;
        check("wr_ready_lat", 32'(consumer_write_ready[a[1:0]]), 32'd1);
        check("wr_valid_drop", 32'(mem_write_valid[ch]), 32'd0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int n;
    int ch;
    int last;
    int served;
    int exp_srv;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;

    for (int i = 0; i < 256; i++) begin
      mem_arr[i]   = 16'(i * 257) ^ 16'h3C3C;
      model_arr[i] = mem_arr[i];
    end

    // Reset state
    repeat (2) step();
    check("rst_crr", 32'(consumer_read_ready), 32'd0);
    check("rst_cwr", 32'(consumer_write_ready), 32'd0);
    check("rst_crd", 32'(consumer_read_data[31:0]), 32'd0);
    check("rst_mrv", 32'(mem_read_valid), 32'd0);
    check("rst_mwv", 32'(mem_write_valid), 32'd0);
    check("rst_mwd", 32'(mem_write_data), 32'd0);
    reset = 1'b0;
    step();

    // Single read: consumer 2 @0x1A, memory answers 3 cycles later
    consumer_read_address[2*AW +: AW] = 8'h1A;
    consumer_read_valid[2] = 1'b1;
    step();
    check("rd_issue_valid", 32'(mem_read_valid), 32'h1);
    check("rd_issue_addr", 32'(mem_read_address[7:0]), 32'h1A);
    check("rd_no_early_ready", 32'(consumer_read_ready), 32'h0);
    repeat (2) begin
      step();
      check("rd_wait_hold", 32'(mem_read_valid), 32'h1);
    end
    mem_read_data[15:0] = 16'hBEEF;
    mem_read_ready[0] = 1'b1;
    step();
    mem_read_ready[0] = 1'b0;
    check("rd_ready", 32'(consumer_read_ready), 32'h4);
    check("rd_data", 32'(consumer_read_data[2*DW +: DW]), 32'hBEEF);
    check("rd_mem_drop", 32'(mem_read_valid), 32'h0);
    repeat (2) begin
      step();
      check("rd_ready_held", 32'(consumer_read_ready), 32'h4);
    end
    consumer_read_valid[2] = 1'b0;
    step();
    check("rd_ready_clr", 32'(consumer_read_ready), 32'h0);

    // Single write: consumer 0 writes 0x55AA to 0x03
    base = wr_req_cnt;
    consumer_write_address[7:0] = 8'h03;
    consumer_write_data[15:0]   = 16'h55AA;
    consumer_write_valid[0]     = 1'b1;
    step();
    check("wr_issue_valid", 32'(mem_write_valid), 32'h1);
    check("wr_issue_addr", 32'(mem_write_address[7:0]), 32'h03);
    check("wr_issue_data", 32'(mem_write_data[15:0]), 32'h55AA);
    mem_write_ready[0] = 1'b1;
    step();
    mem_write_ready[0] = 1'b0;
    check("wr_ready", 32'(consumer_write_ready), 32'h1);
    check("wr_mem_drop", 32'(mem_write_valid), 32'h0);
    repeat (2) begin
      step();
      check("wr_no_reissue", 32'(mem_write_valid), 32'h0);
    end
    consumer_write_valid[0] = 1'b0;
    step();
    check("wr_ready_clr", 32'(consumer_write_ready), 32'h0);
    check("wr_one_request", 32'(wr_req_cnt - base), 32'd1);

    // Oversubscription: four readers, two channels
    base = rd_req_cnt;
    for (int i = 0; i < 4; i++) consumer_read_address[i*AW +: AW] = 8'(8'h40 + i);
    consumer_read_valid = 4'hF;
    step();
    check("os1_valid", 32'(mem_read_valid), 32'h3);
    a0 = mem_read_address[7:0];
    a1 = mem_read_address[15:8];
    check("os1_pair", 32'((a0 < a1) ? {a0, a1} : {a1, a0}), 32'h4041);
    for (int c = 0; c < 2; c++) mem_read_data[c*DW +: DW] = {8'hD0, mem_read_address[c*AW +: AW]};
    mem_read_ready = 2'b11;
    step();
    mem_read_ready = 2'b00;
    check("os1_ready", 32'(consumer_read_ready), 32'h3);
    check("os1_data0", 32'(consumer_read_data[15:0]), 32'hD040);
    check("os1_data1", 32'(consumer_read_data[31:16]), 32'hD041);
    consumer_read_valid[1:0] = 2'b00;
    step();
    check("os_release", 32'({consumer_read_ready, 2'(mem_read_valid)}), 32'h0);
    step();
    check("os2_valid", 32'(mem_read_valid), 32'h3);
    a0 = mem_read_address[7:0];
    a1 = mem_read_address[15:8];
    check("os2_pair", 32'((a0 < a1) ? {a0, a1} : {a1, a0}), 32'h4243);
    for (int c = 0; c < 2; c++) mem_read_data[c*DW +: DW] = {8'hD0, mem_read_address[c*AW +: AW]};
    mem_read_ready = 2'b11;
    step();
    mem_read_ready = 2'b00;
    check("os2_ready", 32'(consumer_read_ready), 32'hC);
    check("os2_data2", 32'(consumer_read_data[47:32]), 32'hD042);
    check("os2_data3", 32'(consumer_read_data[63:48]), 32'hD043);
    consumer_read_valid = 4'h0;
    step();
    check("os2_clr", 32'(consumer_read_ready), 32'h0);
    check("os_four_requests", 32'(rd_req_cnt - base), 32'd4);

    // Duplicate service: consumer 1 holds valid well past its ready
    base = rd_req_cnt;
    consumer_read_address[1*AW +: AW] = 8'h21;
    consumer_read_valid[1] = 1'b1;
    step();
    check("dup_one_channel", 32'($countones(mem_read_valid)), 32'd1);
    ch = mem_read_valid[0] ? 0 : 1;
    mem_read_data[ch*DW +: DW] = 16'h2121;
    mem_read_ready[ch] = 1'b1;
    step();
    mem_read_ready = 2'b00;
    check("dup_ready", 32'(consumer_read_ready), 32'h2);
    check("dup_data", 32'(consumer_read_data[31:16]), 32'h2121);
    repeat (4) begin
      step();
      check("dup_no_reissue", 32'(mem_read_valid), 32'h0);
    end
    consumer_read_valid[1] = 1'b0;
    step();
    check("dup_clr", 32'(consumer_read_ready), 32'h0);
    check("dup_one_request", 32'(rd_req_cnt - base), 32'd1);

    // Fairness with a single usable channel: park channel 1 on an unanswered read
    consumer_read_address[1*AW +: AW] = 8'h31;
    consumer_read_valid[1] = 1'b1;
    step();
    check("fair_setup0", 32'(mem_read_valid), 32'h1);
    consumer_read_address[2*AW +: AW] = 8'h32;
    consumer_read_valid[2] = 1'b1;
    step();
    check("fair_setup1", 32'(mem_read_valid), 32'h3);
    mem_read_data[15:0] = 16'h3131;
    mem_read_ready[0] = 1'b1;
    step();
    mem_read_ready[0] = 1'b0;
    check("fair_setup_ready", 32'(consumer_read_ready[1]), 32'd1);
    consumer_read_valid[1] = 1'b0;
    step();
    consumer_read_address[0*AW +: AW] = 8'h30;
    consumer_read_address[3*AW +: AW] = 8'h33;
    consumer_read_valid[0] = 1'b1;
    consumer_read_valid[3] = 1'b1;
    last = 1;
    for (int r = 0; r < 4; r++) begin
      n = 0;
      do begin
        step();
        n++;
      end while (!mem_read_valid[0] && n < 10);
      check("fair_grant", 32'(mem_read_valid[0]), 32'd1);
      served = int'(mem_read_address[1:0]);
`ifdef MEM_CTRL_RR_EN
      exp_srv = rr_next(last);
`else
      exp_srv = 0;
`endif
      check("fair_order", 32'(served), 32'(exp_srv));
      mem_read_data[15:0] = 16'(16'hF000 + r);
      mem_read_ready[0] = 1'b1;
      step();
      mem_read_ready[0] = 1'b0;
      check("fair_ready", 32'(consumer_read_ready[served]), 32'd1);
      consumer_read_valid[served] = 1'b0;
      step();
      consumer_read_valid[served] = 1'b1;
      last = served;
    end

    // Async reset while both channels sit in READ_WAITING
    step();
    check("arst_pre_busy", 32'(mem_read_valid), 32'h3);
    #2 reset = 1'b1;
    #1;
    check("arst_mrv", 32'(mem_read_valid), 32'h0);
    check("arst_mra", 32'(mem_read_address), 32'h0);
    check("arst_crr", 32'(consumer_read_ready), 32'h0);
    check("arst_crd", 32'(consumer_read_data[47:16]), 32'h0);
    @(negedge clk);
    consumer_read_valid = '0;
    consumer_write_valid = '0;
    @(negedge clk);
    reset = 1'b0;
    consumer_read_address[3*AW +: AW] = 8'h77;
    consumer_read_valid[3] = 1'b1;
    step();
    check("post_rst_valid", 32'(mem_read_valid), 32'h1);
    check("post_rst_addr", 32'(mem_read_address[7:0]), 32'h77);
    mem_read_data[15:0] = 16'h1234;
    mem_read_ready[0] = 1'b1;
    step();
    mem_read_ready[0] = 1'b0;
    check("post_rst_ready", 32'(consumer_read_ready), 32'h8);
    check("post_rst_data", 32'(consumer_read_data[63:48]), 32'h1234);
    consumer_read_valid[3] = 1'b0;
    step();
    check("post_rst_clr", 32'(consumer_read_ready), 32'h0);

    // Random traffic: each LSU owns addresses with addr[1:0] == its index
    base = rd_req_cnt + wr_req_cnt;
    done_cnt = 0;
    fork
      begin
        fork
          lsu_run(0);
          lsu_run(1);
          lsu_run(2);
          lsu_run(3);
        join
        rand_done = 1'b1;
      end
      mem_run(0);
      mem_run(1);
    join
    step();
    check("rand_all_done", 32'(done_cnt), 32'(NC * N_RAND));
    check("rand_req_count", 32'(rd_req_cnt + wr_req_cnt - base), 32'(NC * N_RAND));
    check("rand_idle", 32'({mem_read_valid, mem_write_valid}), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
